// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between IF-stage fetches and MEM-stage loads/stores.
// Define ARB_RR_EN for round-robin priority; the default build uses fixed DM-over-IM priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  im_req,
  input  logic [31:0]           im_addr,
  output logic                  im_rvalid,
  output logic [DATA_WIDTH-1:0] im_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [3:0]            dm_wstrb,
  input  logic [31:0]           dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_done,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  pipe_stall,
  output logic                  sram_cs,
  output logic                  sram_oe,
  output logic [3:0]            sram_web,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_di,
  input  logic [DATA_WIDTH-1:0] sram_do
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP} state_t;
  typedef enum logic {OWN_IM = 1'b0, OWN_DM = 1'b1} owner_t;

  state_t                state, state_nxt;
  owner_t                owner, grant;
  logic                  grant_valid;
  logic                  dm_first;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [3:0]            wstrb_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  im_pend, dm_pend;
  logic                  addr_unused;

  // A requester whose done pulse is showing this cycle is already served.
  assign im_pend    = im_req & ~im_rvalid;
  assign dm_pend    = dm_req & ~dm_done;
  assign pipe_stall = im_pend | dm_pend;

  assign addr_unused = ^{im_addr[31:ADDR_WIDTH+2], im_addr[1:0],
                         dm_addr[31:ADDR_WIDTH+2], dm_addr[1:0]};

`ifdef ARB_RR_EN
  owner_t last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              last_q <= OWN_IM;
    else if (grant_valid) last_q <= grant;
  end

  assign dm_first = (last_q == OWN_IM);
`else
  assign dm_first = 1'b1;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt   = state;
    grant_valid = 1'b0;
    if (im_pend && dm_pend) grant = dm_first ? OWN_DM : OWN_IM;
    else                    grant = dm_pend  ? OWN_DM : OWN_IM;
    unique case (state)
      S_IDLE, S_RESP: begin
        grant_valid = im_pend | dm_pend;
        state_nxt   = grant_valid ? S_ACC : S_IDLE;
      end
      S_ACC:   state_nxt = S_RESP;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      owner     <= OWN_IM;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      im_rvalid <= 1'b0;
      dm_done   <= 1'b0;
      im_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      state     <= state_nxt;
      im_rvalid <= (state == S_ACC) && (owner == OWN_IM);
      dm_done   <= (state == S_ACC) && (owner == OWN_DM);
      if (grant_valid) begin
        owner <= grant;
        if (grant == OWN_DM) begin
          addr_q  <= dm_addr[ADDR_WIDTH+1:2];
          we_q    <= dm_we;
          wstrb_q <= dm_wstrb;
          wdata_q <= dm_wdata;
        end else begin
          addr_q  <= im_addr[ADDR_WIDTH+1:2];
          we_q    <= 1'b0;
          wstrb_q <= '0;
        end
      end
      // Read data is sampled as ACC closes; writes leave dm_rdata untouched.
      if (state == S_ACC && !we_q) begin
        if (owner == OWN_IM) im_rdata <= sram_do;
        else                 dm_rdata <= sram_do;
      end
    end
  end

  // SRAM pins decode only registered state, so an async reset drops them at once.
  assign sram_cs  = (state == S_ACC);
  assign sram_oe  = (state == S_ACC) && !we_q;
  assign sram_web = (state == S_ACC && we_q) ? ~wstrb_q : 4'hF;
  assign sram_a   = addr_q;
  assign sram_di  = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench for mem_port_arbiter with a behavioural SRAM and
// a transaction-level model (shadow memory, grant order, expected completion cycles).
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          im_req, dm_req, dm_we;
  logic [31:0]   im_addr, dm_addr;
  logic [3:0]    dm_wstrb;
  logic [DW-1:0] dm_wdata;
  logic          im_rvalid, dm_done, pipe_stall;
  logic [DW-1:0] im_rdata, dm_rdata;
  logic          sram_cs, sram_oe;
  logic [3:0]    sram_web;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_di, sram_do;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .im_req(im_req), .im_addr(im_addr), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .pipe_stall(pipe_stall),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web), .sram_a(sram_a),
    .sram_di(sram_di), .sram_do(sram_do)
  );

  // Behavioural SRAM: data follows the address combinationally, byte writes on the edge.
  logic [31:0] mem       [0:(1<<AW)-1];
  logic [31:0] model_mem [0:(1<<AW)-1];
  assign sram_do = mem[sram_a];

  always @(posedge clk) begin
    if (sram_cs)
      for (int b = 0; b < 4; b++)
        if (!sram_web[b]) mem[sram_a][8*b +: 8] = sram_di[8*b +: 8];
  end

  int n_checks = 0;
  int n_pass   = 0;
  bit last_dm  = 1'b0;  // model's last-served requester, 1 = DM

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    return {16'($urandom), 6'b0, 8'($urandom), 2'($urandom)};
  endfunction

  // One episode from idle: optional IM read and/or DM access raised in the same cycle.
  task automatic episode(input bit do_im, input bit do_dm, input logic [31:0] ia,
                         input logic [31:0] da, input bit we, input logic [3:0] ws,
                         input logic [31:0] wd, input bit drop_early);
    bit            dm_wins, two, im_on, dm_on, is_dm;
    int            im_cyc, dm_cyc, last_c, s;
    logic [31:0]   im_exp, dm_exp;
    logic [AW-1:0] iw, dw;
    logic [AW-1:0] acc_a   [2];
    bit            acc_wr  [2];
    logic [3:0]    acc_web [2];

    iw      = ia[AW+1:2];
    dw      = da[AW+1:2];
    two     = do_im && do_dm;
    dm_wins = two ? (RR ? !last_dm : 1'b1) : do_dm;
    im_exp  = '0;
    dm_exp  = '0;
    im_cyc  = -1;
    dm_cyc  = -1;
    for (int k = 0; k < (two ? 2 : 1); k++) begin
      is_dm = (k == 0) ? dm_wins : !dm_wins;
      if (is_dm) begin
        dm_cyc     = 2*k + 2;
        acc_a[k]   = dw;
        acc_wr[k]  = we;
        acc_web[k] = we ? ~ws : 4'hF;
        if (we) model_mem[dw] = merge(model_mem[dw], wd, ws);
        else    dm_exp = model_mem[dw];
      end else begin
        im_cyc     = 2*k + 2;
        acc_a[k]   = iw;
        acc_wr[k]  = 1'b0;
        acc_web[k] = 4'hF;
        im_exp     = model_mem[iw];
      end
      last_dm = is_dm;
    end
    last_c = two ? 5 : 3;

    @(negedge clk);
    im_req = do_im; im_addr = ia;
    dm_req = do_dm; dm_addr = da; dm_we = we; dm_wstrb = ws; dm_wdata = wd;
    im_on  = do_im; dm_on = do_dm;
    for (int c = 0; c <= last_c; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check("pipe_stall", pipe_stall, (im_on && c != im_cyc) || (dm_on && c != dm_cyc));
      check("im_rvalid", im_rvalid, c == im_cyc);
      check("dm_done", dm_done, c == dm_cyc);
      check("sram_cs", sram_cs, c == 1 || (two && c == 3));
      if (c == 1 || (two && c == 3)) begin
        s = (c - 1) / 2;
        check("sram_a", sram_a, acc_a[s]);
        check("sram_oe", sram_oe, !acc_wr[s]);
        check("sram_web", sram_web, acc_web[s]);
        if (acc_wr[s]) check("sram_di", sram_di, wd);
      end
      if (c == im_cyc) check("im_rdata", im_rdata, im_exp);
      if (c == dm_cyc && !we) check("dm_rdata", dm_rdata, dm_exp);
      if (c == im_cyc || (drop_early && c == 1 && !dm_wins)) begin im_req = 1'b0; im_on = 1'b0; end
      if (c == dm_cyc || (drop_early && c == 1 &&  dm_wins)) begin dm_req = 1'b0; dm_on = 1'b0; end
    end
  endtask

  // Both requesters hold their read requests for eight back-to-back transactions.
  task automatic rr_stream(input logic [31:0] ia, input logic [31:0] da);
    bit            next_dm;
    int            n_im, n_dm;
    logic [AW-1:0] iw, dw;
    iw      = ia[AW+1:2];
    dw      = da[AW+1:2];
    n_im    = 0;
    n_dm    = 0;
    next_dm = RR ? !last_dm : 1'b1;
    @(negedge clk);
    im_req = 1'b1; im_addr = ia;
    dm_req = 1'b1; dm_addr = da; dm_we = 1'b0; dm_wstrb = 4'h0;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check("rr_stall", pipe_stall, 1'b1);
      if (c >= 2 && c % 2 == 0) begin
        check("rr_im_rvalid", im_rvalid, !next_dm);
        check("rr_dm_done", dm_done, next_dm);
        if (next_dm) check("rr_dm_rdata", dm_rdata, model_mem[dw]);
        else         check("rr_im_rdata", im_rdata, model_mem[iw]);
        n_im   += int'(im_rvalid);
        n_dm   += int'(dm_done);
        last_dm = next_dm;
        next_dm = !next_dm;
      end else begin
        check("rr_no_pulse", im_rvalid | dm_done, 1'b0);
      end
    end
    check("rr_im_count", n_im, 4);
    check("rr_dm_count", n_dm, 4);
    im_req = 1'b0;
    dm_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rr_quiet_cs", sram_cs, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]       = $urandom;
      model_mem[i] = mem[i];
    end
    rst = 1'b1;
    im_req = 1'b0; im_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_wstrb = '0; dm_addr = '0; dm_wdata = '0;

    // Reset values, then a quiet idle window.
    repeat (3) @(negedge clk);
    #1;
    check("rst_im_rvalid", im_rvalid, 1'b0);
    check("rst_dm_done", dm_done, 1'b0);
    check("rst_sram_cs", sram_cs, 1'b0);
    check("rst_sram_oe", sram_oe, 1'b0);
    check("rst_sram_web", sram_web, 4'hF);
    check("rst_sram_a", sram_a, '0);
    check("rst_sram_di", sram_di, '0);
    check("rst_im_rdata", im_rdata, '0);
    check("rst_dm_rdata", dm_rdata, '0);
    check("rst_pipe_stall", pipe_stall, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("idle_cs", sram_cs, 1'b0);
      check("idle_web", sram_web, 4'hF);
      check("idle_pulses", im_rvalid | dm_done, 1'b0);
    end

    // Single fetch from word 0x10.
    mem[14'h10] = 32'hDEADBEEF; model_mem[14'h10] = 32'hDEADBEEF;
    episode(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    check("fetch_rdata", im_rdata, 32'hDEADBEEF);

    // Byte write into word 0x40, read back, then a no-strobe write.
    mem[14'h40] = 32'h11223344; model_mem[14'h40] = 32'h11223344;
    episode(1'b0, 1'b1, 32'h0, 32'h100, 1'b1, 4'b0010, 32'h0000AB00, 1'b0);
    episode(1'b0, 1'b1, 32'h0, 32'h100, 1'b0, 4'h0, 32'h0, 1'b0);
    check("byte_rdata", dm_rdata, 32'h1122AB44);
    episode(1'b0, 1'b1, 32'h0, 32'h100, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b0);
    episode(1'b0, 1'b1, 32'h0, 32'h100, 1'b0, 4'h0, 32'h0, 1'b0);
    check("nostrb_rdata", dm_rdata, 32'h1122AB44);

    // Contention in the same cycle, and a requester that drops after its grant.
    episode(1'b1, 1'b1, 32'h40, 32'h104, 1'b0, 4'h0, 32'h0, 1'b0);
    episode(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);

    rr_stream(32'h48, 32'h4C);

    // Async reset during the ACC cycle of a write must abort it.
    mem[14'h80] = 32'h55AA55AA; model_mem[14'h80] = 32'h55AA55AA;
    @(negedge clk);
    #1;
    dm_req = 1'b1; dm_we = 1'b1; dm_wstrb = 4'hF; dm_addr = 32'h200; dm_wdata = 32'hCAFEF00D;
    @(negedge clk);
    #1;
    check("abort_pre_cs", sram_cs, 1'b1);
    check("abort_pre_web", sram_web, 4'h0);
    rst = 1'b1;
    #1;
    check("abort_web", sram_web, 4'hF);
    check("abort_cs", sram_cs, 1'b0);
    dm_req = 1'b0; dm_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("abort_no_done", dm_done, 1'b0);
    end
    rst     = 1'b0;
    last_dm = 1'b0;
    episode(1'b0, 1'b1, 32'h0, 32'h200, 1'b0, 4'h0, 32'h0, 1'b0);
    check("abort_mem", dm_rdata, 32'h55AA55AA);

    // Randomised mix of single and contending accesses.
    for (int k = 0; k < 40; k++) begin
      int mode;
      mode = $urandom_range(0, 2);
      episode(mode != 1, mode != 0, rand_addr(), rand_addr(), 1'($urandom_range(0, 1)),
              4'($urandom), $urandom, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
